// File: rtl/decoder_pg_fifo_if.sv
// Bundle for the decode/FIFO block: producer side (instruction, in_valid/in_ready),
// decode tap (decode_o) and consumer side (data_o, out_valid/out_ready, count_o).
interface decoder_pg_fifo_if #(
  parameter int XLEN      = 32,
  parameter int DATA_SIZE = 33,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]      instruction;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           decode_o;
  logic [DATA_SIZE-1:0] data_o;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        count_o;

  modport master (
    output instruction, in_valid, out_ready,
    input  in_ready, decode_o, data_o, out_valid, count_o
  );

  modport slave (
    input  instruction, in_valid, out_ready,
    output in_ready, decode_o, data_o, out_valid, count_o
  );
endinterface

// File: rtl/decoder_pg_fifo.sv
// RV32I class decoder feeding a show-ahead FIFO of {decode, instruction[31:7]} entries.
// Optional macro DECODER_PG_ILLEGAL_FILTER_EN drops entries whose class code is 0x00.
module decoder_pg_fifo #(
  parameter int XLEN      = 32,
  parameter int DATA_SIZE = 33,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  decoder_pg_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       b20;
  logic [7:0] decode;

  assign opcode = bus.instruction[6:0];
  assign f3     = bus.instruction[14:12];
  assign f7     = bus.instruction[31:25];
  assign b20    = bus.instruction[20];

  always_comb begin
    decode = 8'h00;
    case (opcode)
      7'b0110111: decode = 8'h01;
      7'b0010111: decode = 8'h02;
      7'b0010011: begin
        if (f3 == 3'b001)      decode = (f7 == 7'b0000000) ? 8'h03 : 8'h00;
        else if (f3 == 3'b101) decode = (f7 == 7'b0000000 || f7 == 7'b0100000) ? 8'h03 : 8'h00;
        else                   decode = 8'h03;
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) decode = 8'h04;
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) decode = 8'h04;
      end
      7'b0000011: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101)
          decode = 8'h05;
      end
      7'b0100011: if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) decode = 8'h06;
      7'b1101111: decode = 8'h07;
      7'b1100111: if (f3 == 3'b000) decode = 8'h08;
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) decode = 8'h09;
      7'b1110011: if (f3 == 3'b000) decode = b20 ? 8'h0B : 8'h0A;
      7'b0001111: decode = 8'h0C;
      default:    decode = 8'h00;
    endcase
  end

  assign bus.decode_o = decode;

  // Handshakes: a transfer happens on the posedge where valid && ready are both high.
  // in_ready is !full only (no bypass when full); out_valid is !empty. Neither ready
  // depends on the same-cycle valid of the other side.
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 push;
  logic                 pop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = bus.in_valid && !full;
  assign pop    = bus.out_valid && bus.out_ready;

`ifdef DECODER_PG_ILLEGAL_FILTER_EN
  // Illegal words are handshaken normally but never stored.
  assign push = accept && (decode != 8'h00);
`else
  assign push = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= {decode, bus.instruction[XLEN-1:7]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.data_o    = empty ? '0 : mem[rd_ptr];
  assign bus.count_o   = count;
endmodule

// File: tb/tb_decoder_pg_fifo.sv
// Bench for decoder_pg_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decoder_pg_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  decoder_pg_fifo_if #(.XLEN(32), .DATA_SIZE(33), .DEPTH(DEPTH)) bus ();

  decoder_pg_fifo #(.XLEN(32), .DATA_SIZE(33), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference classifier: legal-f3 sets as bitmasks indexed by funct3
  function automatic logic [7:0] ref_class(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h37) return 8'h01;
    if (op == 7'h17) return 8'h02;
    if (op == 7'h13) begin
      if (f3 == 3'd1 && f7 != 7'h00) return 8'h00;
      if (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) return 8'h00;
      return 8'h03;
    end
    if (op == 7'h33) begin
      if (f7 == 7'h00) return 8'h04;
      if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return 8'h04;
      return 8'h00;
    end
    if (op == 7'h03) return ((8'h37 >> f3) & 8'h01) != 0 ? 8'h05 : 8'h00;
    if (op == 7'h23) return ((8'h07 >> f3) & 8'h01) != 0 ? 8'h06 : 8'h00;
    if (op == 7'h6F) return 8'h07;
    if (op == 7'h67) return (f3 == 3'd0) ? 8'h08 : 8'h00;
    if (op == 7'h63) return ((8'hF3 >> f3) & 8'h01) != 0 ? 8'h09 : 8'h00;
    if (op == 7'h73 && f3 == 3'd0) return w[20] ? 8'h0B : 8'h0A;
    if (op == 7'h0F) return 8'h0C;
    return 8'h00;
  endfunction

  // scoreboard: expected FIFO contents
  logic [32:0] exp_q[$];
  bit          model_live = 0;

  always @(posedge clk) begin
    logic [32:0] entry;
    bit          do_push;
    bit          do_pop;
    if (!rst_n) begin
      exp_q.delete();
      model_live = 1;
    end else if (model_live) begin
      entry   = {ref_class(bus.instruction), bus.instruction[31:7]};
      do_push = bus.in_valid && (exp_q.size() < DEPTH);
      do_pop  = bus.out_ready && (exp_q.size() > 0);
`ifdef DECODER_PG_ILLEGAL_FILTER_EN
      if (entry[32:25] == 8'h00) do_push = 0;
`endif
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(entry);
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("decode_o", {56'h0, bus.decode_o}, {56'h0, ref_class(bus.instruction)});
    if (model_live) begin
      chk("count_o",   {{(64-CW){1'b0}}, bus.count_o}, 64'(exp_q.size()));
      chk("in_ready",  {63'h0, bus.in_ready},  {63'h0, (exp_q.size() < DEPTH)});
      chk("out_valid", {63'h0, bus.out_valid}, {63'h0, (exp_q.size() > 0)});
      chk("data_o",    {31'h0, bus.data_o},    {31'h0, (exp_q.size() > 0) ? exp_q[0] : 33'h0});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic iv, input logic ordy);
    bus.instruction = w;
    bus.in_valid    = iv;
    bus.out_ready   = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0] tbl_w [16];
  logic [7:0]  tbl_c [16];

  initial begin
    tbl_w[0]  = 32'h00000037; tbl_c[0]  = 8'h01;
    tbl_w[1]  = 32'h00000017; tbl_c[1]  = 8'h02;
    tbl_w[2]  = 32'h00000013; tbl_c[2]  = 8'h03;
    tbl_w[3]  = 32'h40005013; tbl_c[3]  = 8'h03;
    tbl_w[4]  = 32'h40001013; tbl_c[4]  = 8'h00;
    tbl_w[5]  = 32'h40000033; tbl_c[5]  = 8'h04;
    tbl_w[6]  = 32'h40001033; tbl_c[6]  = 8'h00;
    tbl_w[7]  = 32'h00002003; tbl_c[7]  = 8'h05;
    tbl_w[8]  = 32'h00003003; tbl_c[8]  = 8'h00;
    tbl_w[9]  = 32'h00002023; tbl_c[9]  = 8'h06;
    tbl_w[10] = 32'h00000067; tbl_c[10] = 8'h08;
    tbl_w[11] = 32'h00000063; tbl_c[11] = 8'h09;
    tbl_w[12] = 32'h00002063; tbl_c[12] = 8'h00;
    tbl_w[13] = 32'h0000000F; tbl_c[13] = 8'h0C;
    tbl_w[14] = 32'h00100073; tbl_c[14] = 8'h0B;
    tbl_w[15] = 32'h0080006F; tbl_c[15] = 8'h07;

    rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    do_reset();

    // pin the reference classifier and the DUT decoder to literal codes
    for (int i = 0; i < 16; i++) begin
      chk("model_table", {56'h0, ref_class(tbl_w[i])}, {56'h0, tbl_c[i]});
      drive(tbl_w[i], 1'b0, 1'b0);
      @(negedge clk);
      chk("decode_table", {56'h0, bus.decode_o}, {56'h0, tbl_c[i]});
      step();
    end

    // JAL push: visible one cycle later
    drive(32'h0080006F, 1'b1, 1'b0);
    @(negedge clk);
    chk("jal_decode", {56'h0, bus.decode_o}, 64'h07);
    chk("jal_empty_before", {{(64-CW){1'b0}}, bus.count_o}, 64'd0);
    step();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("jal_data", {31'h0, bus.data_o}, {31'h0, 8'h07, 25'h0010000});
    chk("jal_valid", {63'h0, bus.out_valid}, 64'd1);

    // EBREAK then ECALL order
    do_reset();
    drive(32'h00100073, 1'b1, 1'b0);
    step();
    drive(32'h00000073, 1'b1, 1'b0);
    step();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("head_ebreak", {56'h0, bus.data_o[32:25]}, 64'h0B);
    drive(32'h0, 1'b0, 1'b1);
    step();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("head_ecall", {56'h0, bus.data_o[32:25]}, 64'h0A);

    // fill, overflow attempt, drain one, refill, full with pop request
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'h00000013 | (32'(i) << 7), 1'b1, 1'b0);
      step();
    end
    drive(32'h0000006F, 1'b1, 1'b0);
    step();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", {{(64-CW){1'b0}}, bus.count_o}, 64'd4);
    chk("full_in_ready", {63'h0, bus.in_ready}, 64'd0);
    chk("full_head", {31'h0, bus.data_o}, {31'h0, 8'h03, 25'h0});
    drive(32'h0, 1'b0, 1'b1);
    step();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain1_count", {{(64-CW){1'b0}}, bus.count_o}, 64'd3);
    chk("drain1_in_ready", {63'h0, bus.in_ready}, 64'd1);
    drive(32'h00000037, 1'b1, 1'b0);
    step();
    drive(32'h00000037, 1'b1, 1'b1);
    @(negedge clk);
    chk("refull_in_ready", {63'h0, bus.in_ready}, 64'd0);
    step();
    @(negedge clk);
    chk("pop_only_count", {{(64-CW){1'b0}}, bus.count_o}, 64'd3);
    step();
    @(negedge clk);
    chk("push_pop_count", {{(64-CW){1'b0}}, bus.count_o}, 64'd3);
    drive(32'h0, 1'b0, 1'b0);

    // illegal OP word
    do_reset();
    drive(32'h40001033, 1'b1, 1'b0);
    @(negedge clk);
    chk("illegal_decode", {56'h0, bus.decode_o}, 64'h00);
    step();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef DECODER_PG_ILLEGAL_FILTER_EN
    chk("illegal_dropped", {{(64-CW){1'b0}}, bus.count_o}, 64'd0);
`else
    chk("illegal_enqueued", {{(64-CW){1'b0}}, bus.count_o}, 64'd1);
    chk("illegal_code", {31'h0, bus.data_o}, {31'h0, 8'h00, 25'h0800020});
`endif

    // reset beats a simultaneous push
    do_reset();
    drive(32'h00000013, 1'b1, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    drive(32'h00000037, 1'b1, 1'b0);
    step();
    rst_n = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_count", {{(64-CW){1'b0}}, bus.count_o}, 64'd0);
    chk("rst_valid", {63'h0, bus.out_valid}, 64'd0);
    chk("rst_data", {31'h0, bus.data_o}, 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      if ($urandom_range(0, 1) == 0) w = $urandom();
      else w = tbl_w[$urandom_range(0, 15)] | ({$urandom()} & 32'hFE0F_8F80);
      drive(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst_n = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    step();
    @(negedge clk);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
